// File: rtl/iopmp_chk_arbiter.sv
// rtl/iopmp_chk_arbiter.sv - round-robin arbiter sharing one IOPMP check unit between NUM_REQ requesters
// Optional response watchdog enabled by defining IOPMP_ARB_TIMEOUT_EN.
module iopmp_chk_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    output logic               chk_valid_o,
    input  logic               chk_ready_i,
    output logic [IDX_W-1:0]   chk_idx_o,
    input  logic               rsp_valid_i,
    output logic [NUM_REQ-1:0] rsp_valid_o,
    output logic               busy_o,
    output logic               timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [IDX_W-1:0] winner, win_masked, win_any;
    logic             masked_hit;
    logic             expire;

    // Lowest set bit at or above rr_ptr, falling back to the lowest set bit overall.
    always_comb begin
        win_masked = '0;
        win_any    = '0;
        masked_hit = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                win_any = IDX_W'(i);
                if (i >= int'(rr_ptr)) begin
                    win_masked = IDX_W'(i);
                    masked_hit = 1'b1;
                end
            end
        end
        winner = masked_hit ? win_masked : win_any;
    end

`ifdef IOPMP_ARB_TIMEOUT_EN
    localparam int WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WD_W   = (WD_RAW < 8) ? 8 : ((WD_RAW > 32) ? 32 : WD_RAW);

    logic [WD_W-1:0] wdog;

    // wdog holds the number of WAIT_RSP cycles already spent, so expiry lands on cycle TIMEOUT_CYCLES.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || state != WAIT_RSP) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end

    assign expire = (state == WAIT_RSP) && !rsp_valid_i && (wdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            rr_ptr <= '0;
            idx    <= '0;
        end else begin
            state  <= state_d;
            rr_ptr <= rr_ptr_d;
            idx    <= idx_d;
        end
    end

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        idx_d       = idx;
        req_ready_o = '0;
        chk_valid_o = 1'b0;
        chk_idx_o   = '0;
        rsp_valid_o = '0;
        timeout_o   = 1'b0;
        busy_o      = (state != IDLE);
        case (state)
            IDLE: begin
                if (|req_valid_i) begin
                    idx_d   = winner;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                chk_valid_o = 1'b1;
                chk_idx_o   = idx;
                if (chk_ready_i) begin
                    req_ready_o = NUM_REQ'(1) << idx;
                    state_d     = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                chk_idx_o = idx;
                if (rsp_valid_i || expire) begin
                    rsp_valid_o = NUM_REQ'(1) << idx;
                    timeout_o   = expire;
                    rr_ptr_d    = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are forced quiet for the whole reset cycle, even mid-transaction.
        if (!rst_ni) begin
            req_ready_o = '0;
            chk_valid_o = 1'b0;
            chk_idx_o   = '0;
            rsp_valid_o = '0;
            timeout_o   = 1'b0;
            busy_o      = 1'b0;
        end
    end

`ifndef SYNTHESIS
    hold_during_issue: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state == ISSUE) |-> req_valid_i[idx]);
    timeout_param_sane: assert property (@(posedge clk_i) TIMEOUT_CYCLES >= 1);
`endif

endmodule
